bus_share_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one 32-bit datapath (a 2:1 select, `sel ? a : b`) between requester A and requester B. It drives the select, accepts at most one transfer per cycle through valid/ready handshakes, and presents the winner's data in a one-entry registered output stage for the downstream consumer. It sits between two producers, for example an instruction-side and a data-side master, and a single shared bus or memory write port.

---
 rtl/bus_share_arbiter.sv | 109 ++++++++++
 tb/tb_bus_share_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bus_share_arbiter.sv
// Two-requester round-robin arbiter driving a shared 2:1 datapath select
// and a one-entry registered output stage with per-requester counters.
module bus_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_src_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_b_q;

  logic             out_valid_d;
  logic [WIDTH-1:0] out_data_d;
  logic             out_src_d;
  logic             last_grant_d;
  logic [CNT_W-1:0] cnt_a_d;
  logic [CNT_W-1:0] cnt_b_d;

  logic             can_load;
  logic             sel_w;
  logic             a_acc;
  logic             b_acc;

  assign can_load = !out_valid_q || out_ready;

  // Ties go to whoever was not granted last; idle holds the last grant.
  always_comb begin
    sel_w = last_grant_q;
    unique case (1'b1)
      (a_valid && !b_valid): sel_w = 1'b1;
      (!a_valid && b_valid): sel_w = 1'b0;
      (a_valid && b_valid):  sel_w = !last_grant_q;
      default:               sel_w = last_grant_q;
    endcase
  end

  assign a_acc = !reset && can_load && a_valid && sel_w;
  assign b_acc = !reset && can_load && b_valid && !sel_w;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    cnt_a_d      = cnt_a_q;
    cnt_b_d      = cnt_b_q;
    if (a_acc || b_acc) begin
      out_valid_d  = 1'b1;
      out_data_d   = sel_w ? a_data : b_data;
      out_src_d    = sel_w;
      last_grant_d = sel_w;
      if (a_acc && !(&cnt_a_q)) begin
        cnt_a_d = cnt_a_q + CNT_W'(1);
      end
      if (b_acc && !(&cnt_b_q)) begin
        cnt_b_d = cnt_b_q + CNT_W'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= 1'b0;
      last_grant_q <= 1'b0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
    end
  end

  assign sel       = sel_w;
  assign a_ready   = a_acc;
  assign b_ready   = b_acc;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign cnt_a     = cnt_a_q;
  assign cnt_b     = cnt_b_q;

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Directed table-driven bench for bus_share_arbiter, plus a
// counter-saturation sequence on a CNT_W=4 instance.
module tb_bus_share_arbiter;

  logic        clk;
  logic        reset;
  logic        a_valid;
  logic [31:0] a_data;
  logic        b_valid;
  logic [31:0] b_data;
  logic        out_ready;

  logic        a_ready, b_ready, sel, out_valid, out_src;
  logic [31:0] out_data;
  logic [15:0] cnt_a, cnt_b;

  logic        s_a_ready, s_b_ready, s_sel, s_out_valid, s_out_src;
  logic [31:0] s_out_data;
  logic [3:0]  s_cnt_a, s_cnt_b;

  int ncmp;
  int nfail;

  bus_share_arbiter u_dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  bus_share_arbiter #(.WIDTH(32), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(s_a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(s_b_ready),
    .sel(s_sel), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_src(s_out_src), .out_ready(out_ready),
    .cnt_a(s_cnt_a), .cnt_b(s_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av;
    logic [31:0] ad;
    logic        bv;
    logic [31:0] bd;
    logic        ordy;
    logic        e_ar;
    logic        e_br;
    logic        e_sel;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_src;
    logic [15:0] e_ca;
    logic [15:0] e_cb;
  } vec_t;

  vec_t vt[19];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rst, input logic av, input logic [31:0] ad,
    input logic bv, input logic [31:0] bd, input logic ordy,
    input logic e_ar, input logic e_br, input logic e_sel,
    input logic e_ov, input logic [31:0] e_od, input logic e_src,
    input logic [15:0] e_ca, input logic [15:0] e_cb);
    vec_t v;
    v.rst = rst; v.av = av; v.ad = ad; v.bv = bv; v.bd = bd;
    v.ordy = ordy; v.e_ar = e_ar; v.e_br = e_br; v.e_sel = e_sel;
    v.e_ov = e_ov; v.e_od = e_od; v.e_src = e_src;
    v.e_ca = e_ca; v.e_cb = e_cb;
    return v;
  endfunction

  initial begin
    ncmp = 0;
    nfail = 0;
    //          rst av ad            bv bd            ordy ar br sel ov od            src ca cb
    vt[0]  = mk(0, 1, 32'h11111111, 0, 32'h0,        1, 1, 0, 1, 1, 32'h11111111, 1, 1, 0);
    vt[1]  = mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 0, 1, 0, 32'h0,        0, 0, 0);
    vt[2]  = mk(0, 1, 32'hAAAA0000, 1, 32'hBBBB0000, 1, 1, 0, 1, 1, 32'hAAAA0000, 1, 1, 0);
    vt[3]  = mk(0, 1, 32'hAAAA0001, 1, 32'hBBBB0000, 1, 0, 1, 0, 1, 32'hBBBB0000, 0, 1, 1);
    vt[4]  = mk(0, 1, 32'hAAAA0001, 1, 32'hBBBB0001, 1, 1, 0, 1, 1, 32'hAAAA0001, 1, 2, 1);
    vt[5]  = mk(0, 1, 32'hAAAA0002, 1, 32'hBBBB0001, 1, 0, 1, 0, 1, 32'hBBBB0001, 0, 2, 2);
    vt[6]  = mk(0, 1, 32'hAAAA0002, 1, 32'hBBBB0002, 1, 1, 0, 1, 1, 32'hAAAA0002, 1, 3, 2);
    vt[7]  = mk(0, 1, 32'hAAAA0003, 1, 32'hBBBB0002, 1, 0, 1, 0, 1, 32'hBBBB0002, 0, 3, 3);
    vt[8]  = mk(0, 1, 32'hAAAA0003, 1, 32'hBBBB0003, 0, 0, 0, 1, 1, 32'hBBBB0002, 0, 3, 3);
    vt[9]  = mk(0, 1, 32'hAAAA0003, 1, 32'hBBBB0003, 0, 0, 0, 1, 1, 32'hBBBB0002, 0, 3, 3);
    vt[10] = mk(0, 1, 32'hAAAA0003, 1, 32'hBBBB0003, 0, 0, 0, 1, 1, 32'hBBBB0002, 0, 3, 3);
    vt[11] = mk(0, 1, 32'hAAAA0003, 1, 32'hBBBB0003, 0, 0, 0, 1, 1, 32'hBBBB0002, 0, 3, 3);
    vt[12] = mk(0, 1, 32'hAAAA0003, 1, 32'hBBBB0003, 1, 1, 0, 1, 1, 32'hAAAA0003, 1, 4, 3);
    vt[13] = mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1, 1, 32'hAAAA0003, 1, 4, 3);
    vt[14] = mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 1, 0, 32'hAAAA0003, 1, 4, 3);
    vt[15] = mk(0, 1, 32'hAAAA0004, 1, 32'hBBBB0004, 0, 0, 1, 0, 1, 32'hBBBB0004, 0, 4, 4);
    vt[16] = mk(0, 1, 32'hAAAA0004, 1, 32'hBBBB0005, 0, 0, 0, 1, 1, 32'hBBBB0004, 0, 4, 4);
    vt[17] = mk(1, 1, 32'hAAAA0004, 1, 32'hBBBB0005, 0, 0, 0, 1, 0, 32'h0,        0, 0, 0);
    vt[18] = mk(0, 1, 32'hAAAA0004, 1, 32'hBBBB0005, 1, 1, 0, 1, 1, 32'hAAAA0004, 1, 1, 0);

    reset = 1'b1;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);
    chk("rst_cnt_a", 32'(cnt_a), 32'h0);
    chk("rst_cnt_b", 32'(cnt_b), 32'h0);
    chk("rst_readies", {30'h0, a_ready, b_ready}, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_sel", 32'(sel), 32'h0);

    for (int i = 0; i < 19; i++) begin
      reset = vt[i].rst;
      a_valid = vt[i].av; a_data = vt[i].ad;
      b_valid = vt[i].bv; b_data = vt[i].bd;
      out_ready = vt[i].ordy;
      #1;
      chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vt[i].e_ar));
      chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vt[i].e_br));
      chk($sformatf("v%0d_sel", i), 32'(sel), 32'(vt[i].e_sel));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
      chk($sformatf("v%0d_out_data", i), out_data, vt[i].e_od);
      chk($sformatf("v%0d_out_src", i), 32'(out_src), 32'(vt[i].e_src));
      chk($sformatf("v%0d_cnt_a", i), 32'(cnt_a), 32'(vt[i].e_ca));
      chk($sformatf("v%0d_cnt_b", i), 32'(cnt_b), 32'(vt[i].e_cb));
    end

    // Saturation: B-only stream on both instances after a fresh reset.
    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      b_valid = 1'b1;
      b_data = 32'hC0DE0000 + 32'(k);
      @(posedge clk);
      @(negedge clk);
      if (k == 15) chk("sat_cnt_b_15", 32'(s_cnt_b), 32'hF);
    end
    b_valid = 1'b0;
    chk("sat_cnt_b_18", 32'(s_cnt_b), 32'hF);
    chk("sat_cnt_a", 32'(s_cnt_a), 32'h0);
    chk("main_cnt_b_18", 32'(cnt_b), 32'd18);
    chk("main_cnt_a_0", 32'(cnt_a), 32'h0);
    chk("sat_out_data", s_out_data, 32'hC0DE0012);
    chk("sat_out_src", 32'(s_out_src), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
